// File: rtl/mux_2to1_arb.sv
// mux_2to1_arb
// Upstream control stage for a 2:1 mux. Round-robin arbitration between two
// valid/ready sources, A and B. While both sources request, one source gets
// at most HOLD consecutive beats. The winning beat is delivered through a
// single output register. Registered se/en tell the downstream stage which
// source produced y_data.
//
// Handshake: a beat moves on a rising edge when its valid and ready are both
// high. x_ready is a combinational function of the state, the valids and
// y_ready. It never depends on x_ready itself. A source must hold x_data and
// x_valid stable until x_ready. The y side follows the same valid/ready rule
// with y_valid/y_ready.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   a_data/a_valid      source A payload and request
//   a_ready             source A beat accepted this cycle
//   b_data/b_valid      source B payload and request
//   b_ready             source B beat accepted this cycle
//   y_data/y_valid      registered output beat
//   y_ready             consumer accepts y_data
//   se                  1 = current y beat came from A, 0 = from B
//   en                  1 = a beat is held, 0 = idle
//   o_dbg_state         arbiter state (0 IDLE, 1 SEL_A, 2 SEL_B)
//   o_dbg_cnt           consecutive beats granted to the current owner
module mux_2to1_arb #(
   parameter int WIDTH = 8,
   parameter int HOLD  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a_data,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [WIDTH-1:0] b_data,
   input  logic             b_valid,
   output logic             b_ready,
   output logic [WIDTH-1:0] y_data,
   output logic             y_valid,
   input  logic             y_ready,
   output logic             se,
   output logic             en,
   output logic [1:0]       o_dbg_state,
   output logic [7:0]       o_dbg_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEL_A = 2'd1,
      SEL_B = 2'd2
   } state_t;

   localparam logic [7:0] C_HOLD = 8'(HOLD);

   state_t           r_state;
   logic [7:0]       r_cnt;
   logic             r_last_a;
   logic [WIDTH-1:0] r_y_data;
   logic             r_y_valid;
   logic             r_se;
   logic             r_en;

   logic             w_load;
   logic             w_at_hold;
   logic             w_gnt_a;
   logic             w_gnt_b;
   logic [7:0]       w_cnt_inc;

   // The output register can take a beat when it is empty or being drained.
   assign w_load    = !r_y_valid || y_ready;
   assign w_at_hold = (r_cnt >= C_HOLD);
   // Saturating increment; cnt never exceeds HOLD.
   assign w_cnt_inc = w_at_hold ? C_HOLD : r_cnt + 8'd1;

   // Grant decision. HOLD matters only when both sources request, so a lone
   // requester is never throttled.
   always_comb begin
      w_gnt_a = 1'b0;
      w_gnt_b = 1'b0;
      if (a_valid && !b_valid) begin
         w_gnt_a = 1'b1;
      end else if (b_valid && !a_valid) begin
         w_gnt_b = 1'b1;
      end else if (a_valid && b_valid) begin
         case (r_state)
            SEL_A: begin
               if (w_at_hold) w_gnt_b = 1'b1;
               else           w_gnt_a = 1'b1;
            end
            SEL_B: begin
               if (w_at_hold) w_gnt_a = 1'b1;
               else           w_gnt_b = 1'b1;
            end
            default: begin
               // From idle, a tie goes to the source that did not win last.
               if (r_last_a) w_gnt_b = 1'b1;
               else          w_gnt_a = 1'b1;
            end
         endcase
      end
   end

   assign a_ready = !rst && w_load && w_gnt_a;
   assign b_ready = !rst && w_load && w_gnt_b;

   // Arbiter FSM and output register. se/en are registered alongside the
   // state, so se == (state == SEL_A) and en == (state != IDLE) always hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= 8'd0;
         r_last_a  <= 1'b0;
         r_y_data  <= '0;
         r_y_valid <= 1'b0;
         r_se      <= 1'b0;
         r_en      <= 1'b0;
      end else if (w_load) begin
         if (w_gnt_a) begin
            r_y_data  <= a_data;
            r_y_valid <= 1'b1;
            r_state   <= SEL_A;
            r_last_a  <= 1'b1;
            r_cnt     <= (r_state == SEL_A) ? w_cnt_inc : 8'd1;
            r_se      <= 1'b1;
            r_en      <= 1'b1;
         end else if (w_gnt_b) begin
            r_y_data  <= b_data;
            r_y_valid <= 1'b1;
            r_state   <= SEL_B;
            r_last_a  <= 1'b0;
            r_cnt     <= (r_state == SEL_B) ? w_cnt_inc : 8'd1;
            r_se      <= 1'b0;
            r_en      <= 1'b1;
         end else begin
            // Nothing to load: go idle. y_data keeps its stale value.
            r_y_valid <= 1'b0;
            r_state   <= IDLE;
            r_cnt     <= 8'd0;
            r_se      <= 1'b0;
            r_en      <= 1'b0;
         end
      end
   end

   assign y_data      = r_y_data;
   assign y_valid     = r_y_valid;
   assign se          = r_se;
   assign en          = r_en;
   assign o_dbg_state = r_state;
   assign o_dbg_cnt   = r_cnt;

endmodule

// File: tb/tb_mux_2to1_arb.sv
// Bench for mux_2to1_arb. Instance 0 uses HOLD=4 and instance 1 uses HOLD=1.
// A source-level arbitration model predicts readies, outputs and the
// burst count on every cycle. A per-instance expected queue tracks the
// beats that have been delivered.
module tb_mux_2to1_arb;

   logic       clk;
   logic       rst;
   logic [7:0] a_data  [2];
   logic       a_valid [2];
   logic [7:0] b_data  [2];
   logic       b_valid [2];
   logic       y_ready [2];
   logic       a_ready [2];
   logic       b_ready [2];
   logic [7:0] y_data  [2];
   logic       y_valid [2];
   logic       se      [2];
   logic       en      [2];
   logic [1:0] dbg_state [2];
   logic [7:0] dbg_cnt   [2];

   int n_checks = 0;
   int n_errors = 0;
   logic chk_on = 1'b0;

   // ---------------------------------------------------------------- clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------- DUTs
   mux_2to1_arb #(.WIDTH(8), .HOLD(4)) u0 (
      .clk(clk), .rst(rst),
      .a_data(a_data[0]), .a_valid(a_valid[0]), .a_ready(a_ready[0]),
      .b_data(b_data[0]), .b_valid(b_valid[0]), .b_ready(b_ready[0]),
      .y_data(y_data[0]), .y_valid(y_valid[0]), .y_ready(y_ready[0]),
      .se(se[0]), .en(en[0]),
      .o_dbg_state(dbg_state[0]), .o_dbg_cnt(dbg_cnt[0])
   );

   mux_2to1_arb #(.WIDTH(8), .HOLD(1)) u1 (
      .clk(clk), .rst(rst),
      .a_data(a_data[1]), .a_valid(a_valid[1]), .a_ready(a_ready[1]),
      .b_data(b_data[1]), .b_valid(b_valid[1]), .b_ready(b_ready[1]),
      .y_data(y_data[1]), .y_valid(y_valid[1]), .y_ready(y_ready[1]),
      .se(se[1]), .en(en[1]),
      .o_dbg_state(dbg_state[1]), .o_dbg_cnt(dbg_cnt[1])
   );

   // ---------------------------------------------------------------- checker
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------- model
   // Source codes: 0 none, 1 A, 2 B.
   int         hold_p [2] = '{4, 1};
   int         m_own  [2];   // source of the beat now held, 0 when idle
   int         m_run  [2];   // consecutive beats of m_own, capped at HOLD
   int         m_last [2];   // source of the most recent accepted beat
   int         m_acc  [2];   // source accepted at the last edge
   logic       m_yv   [2];
   logic [7:0] m_yd   [2];
   logic [7:0] exp_q0 [$];
   logic [7:0] exp_q1 [$];

   function automatic int mgrant(input int i);
      if (rst) return 0;
      if (m_yv[i] && !y_ready[i]) return 0;
      if (a_valid[i] && !b_valid[i]) return 1;
      if (b_valid[i] && !a_valid[i]) return 2;
      if (!a_valid[i]) return 0;
      if (m_own[i] == 0) return (m_last[i] == 1) ? 2 : 1;
      if (m_run[i] < hold_p[i]) return m_own[i];
      return 3 - m_own[i];
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int g;
         g = mgrant(i);
         if (rst) begin
            m_own[i]  <= 0;
            m_run[i]  <= 0;
            m_last[i] <= 2;
            m_acc[i]  <= 0;
            m_yv[i]   <= 1'b0;
            m_yd[i]   <= 8'h00;
            if (i == 0) exp_q0.delete();
            else        exp_q1.delete();
         end else begin
            m_acc[i] <= g;
            if (g != 0) begin
               if (g == m_own[i]) m_run[i] <= (m_run[i] + 1 > hold_p[i]) ? hold_p[i] : m_run[i] + 1;
               else               m_run[i] <= 1;
               m_own[i]  <= g;
               m_last[i] <= g;
               m_yv[i]   <= 1'b1;
               m_yd[i]   <= (g == 1) ? a_data[i] : b_data[i];
               if (i == 0) exp_q0.push_back((g == 1) ? a_data[i] : b_data[i]);
               else        exp_q1.push_back((g == 1) ? a_data[i] : b_data[i]);
            end else if (!m_yv[i] || y_ready[i]) begin
               m_own[i] <= 0;
               m_run[i] <= 0;
               m_yv[i]  <= 1'b0;
            end
         end
      end
   end

   // ---------------------------------------------------------------- compare
   always @(negedge clk) begin
      if (chk_on) begin
         for (int i = 0; i < 2; i++) begin
            int g;
            logic [7:0] f;
            g = mgrant(i);
            chk($sformatf("u%0d.a_ready", i), 32'(a_ready[i]), 32'(g == 1));
            chk($sformatf("u%0d.b_ready", i), 32'(b_ready[i]), 32'(g == 2));
            chk($sformatf("u%0d.y_valid", i), 32'(y_valid[i]), 32'(m_yv[i]));
            chk($sformatf("u%0d.en", i), 32'(en[i]), 32'(m_own[i] != 0));
            chk($sformatf("u%0d.se", i), 32'(se[i]), 32'(m_own[i] == 1));
            chk($sformatf("u%0d.y_data", i), 32'(y_data[i]), 32'(m_yd[i]));
            chk($sformatf("u%0d.cnt", i), 32'(dbg_cnt[i]), 32'(m_run[i]));
            chk($sformatf("u%0d.state_legal", i), 32'(dbg_state[i] == 2'd3), 32'd0);
            if (y_valid[i] && y_ready[i]) begin
               if (i == 0) begin
                  f = (exp_q0.size() > 0) ? exp_q0.pop_front() : 8'hxx;
               end else begin
                  f = (exp_q1.size() > 0) ? exp_q1.pop_front() : 8'hxx;
               end
               chk($sformatf("u%0d.sb_beat", i), 32'(y_data[i]), 32'(f));
            end
         end
      end
   end

   // ---------------------------------------------------------------- drivers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i, input logic av, input logic [7:0] ad,
                        input logic bv, input logic [7:0] bd);
      a_valid[i] = av;
      a_data[i]  = ad;
      b_valid[i] = bv;
      b_data[i]  = bd;
   endtask

   // ---------------------------------------------------------------- stimulus
   int seq3 [12] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1};
   int se5  [4]  = '{0, 0, 0, 1};
   int cnt5 [4]  = '{2, 3, 4, 1};

   initial begin
      int na, nb, ai, bi;
      logic [7:0] ad, bd, ed;

      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive(i, 1'b0, 8'h00, 1'b0, 8'h00);
         y_ready[i] = 1'b1;
      end

      // 1: reset with both requesting on instance 0
      drive(0, 1'b1, 8'h01, 1'b1, 8'h02);
      tick();
      chk_on = 1'b1;
      chk("rst.a_ready", 32'(a_ready[0]), 32'd0);
      chk("rst.b_ready", 32'(b_ready[0]), 32'd0);
      tick();
      chk("rst.y_valid", 32'(y_valid[0]), 32'd0);
      chk("rst.en", 32'(en[0]), 32'd0);
      chk("rst.se", 32'(se[0]), 32'd0);
      chk("rst.y_data", 32'(y_data[0]), 32'd0);
      rst = 1'b0;
      #1;
      chk("rel.a_ready", 32'(a_ready[0]), 32'd1);
      chk("rel.b_ready", 32'(b_ready[0]), 32'd0);
      tick();
      chk("rel.y_data", 32'(y_data[0]), 32'h01);

      // 2: A only stream
      drive(0, 1'b1, 8'h11, 1'b0, 8'h00);
      tick();
      chk("aonly.y0", 32'(y_data[0]), 32'h11);
      chk("aonly.se0", 32'(se[0]), 32'd1);
      a_data[0] = 8'h22;
      tick();
      chk("aonly.y1", 32'(y_data[0]), 32'h22);
      a_data[0] = 8'h33;
      tick();
      chk("aonly.y2", 32'(y_data[0]), 32'h33);
      chk("aonly.en2", 32'(en[0]), 32'd1);
      a_valid[0] = 1'b0;
      tick();
      chk("aonly.en_drop", 32'(en[0]), 32'd0);
      chk("aonly.yv_drop", 32'(y_valid[0]), 32'd0);

      // 3: both continuously valid, HOLD=4, after a fresh reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      na = 0; nb = 0; ai = 0; bi = 0;
      for (int k = 0; k < 12; k++) begin
         drive(0, 1'b1, 8'(8'h40 + na), 1'b1, 8'(8'h80 + nb));
         tick();
         if (m_acc[0] == 1) na++;
         else if (m_acc[0] == 2) nb++;
         if (seq3[k] == 1) begin
            ed = 8'(8'h40 + ai);
            ai++;
         end else begin
            ed = 8'(8'h80 + bi);
            bi++;
         end
         chk($sformatf("rr.se[%0d]", k), 32'(se[0]), 32'(seq3[k] == 1));
         chk($sformatf("rr.y[%0d]", k), 32'(y_data[0]), 32'(ed));
      end

      // 4: backpressure
      drive(0, 1'b1, 8'h5A, 1'b0, 8'h00);
      tick();
      chk("bp.load", 32'(y_data[0]), 32'h5A);
      y_ready[0] = 1'b0;
      drive(0, 1'b1, 8'h5B, 1'b1, 8'h9B);
      #1;
      chk("bp.a_ready", 32'(a_ready[0]), 32'd0);
      chk("bp.b_ready", 32'(b_ready[0]), 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("bp.y[%0d]", k), 32'(y_data[0]), 32'h5A);
         chk($sformatf("bp.se[%0d]", k), 32'(se[0]), 32'd1);
         chk($sformatf("bp.en[%0d]", k), 32'(en[0]), 32'd1);
      end
      y_ready[0] = 1'b1;
      #1;
      chk("bp.rel_b_ready", 32'(b_ready[0]), 32'd1);
      chk("bp.rel_a_ready", 32'(a_ready[0]), 32'd0);
      tick();
      chk("bp.next_y", 32'(y_data[0]), 32'h9B);
      chk("bp.next_se", 32'(se[0]), 32'd0);

      // 5: owner drops, then A reasserts while B owns
      drive(0, 1'b1, 8'h61, 1'b0, 8'h00);
      tick();
      a_data[0] = 8'h62;
      tick();
      chk("own.cnt2", 32'(dbg_cnt[0]), 32'd2);
      chk("own.se", 32'(se[0]), 32'd1);
      drive(0, 1'b0, 8'h00, 1'b1, 8'h71);
      #1;
      chk("own.b_ready", 32'(b_ready[0]), 32'd1);
      tick();
      chk("own.b_se", 32'(se[0]), 32'd0);
      chk("own.b_cnt", 32'(dbg_cnt[0]), 32'd1);
      ad = 8'h63;
      bd = 8'h72;
      for (int k = 0; k < 4; k++) begin
         drive(0, 1'b1, ad, 1'b1, bd);
         tick();
         if (m_acc[0] == 1) ad++;
         else if (m_acc[0] == 2) bd++;
         chk($sformatf("own.se[%0d]", k), 32'(se[0]), 32'(se5[k]));
         chk($sformatf("own.cnt[%0d]", k), 32'(dbg_cnt[0]), 32'(cnt5[k]));
      end
      drive(0, 1'b0, 8'h00, 1'b0, 8'h00);

      // 6a: HOLD=1 alternation on instance 1
      ad = 8'hC0;
      bd = 8'hD0;
      for (int k = 0; k < 6; k++) begin
         drive(1, 1'b1, ad, 1'b1, bd);
         tick();
         if (m_acc[1] == 1) ad++;
         else if (m_acc[1] == 2) bd++;
         chk($sformatf("alt.se[%0d]", k), 32'(se[1]), 32'((k % 2) == 0));
      end
      drive(1, 1'b0, 8'h00, 1'b0, 8'h00);

      // 6b: reset mid-burst on instance 0
      for (int k = 0; k < 3; k++) begin
         drive(0, 1'b1, 8'(8'h20 + k), 1'b0, 8'h00);
         tick();
      end
      chk("mid.cnt3", 32'(dbg_cnt[0]), 32'd3);
      rst = 1'b1;
      drive(0, 1'b1, 8'h30, 1'b1, 8'h31);
      tick();
      chk("mid.rst_yv", 32'(y_valid[0]), 32'd0);
      chk("mid.rst_cnt", 32'(dbg_cnt[0]), 32'd0);
      chk("mid.rst_en", 32'(en[0]), 32'd0);
      rst = 1'b0;
      #1;
      chk("mid.a_ready", 32'(a_ready[0]), 32'd1);
      tick();
      chk("mid.se", 32'(se[0]), 32'd1);
      chk("mid.cnt1", 32'(dbg_cnt[0]), 32'd1);
      chk("mid.y", 32'(y_data[0]), 32'h30);

      // drain
      drive(0, 1'b0, 8'h00, 1'b0, 8'h00);
      for (int k = 0; k < 3; k++) tick();
      chk("end.idle0", 32'(en[0]), 32'd0);
      chk("end.idle1", 32'(en[1]), 32'd0);

      chk_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
